ac_match_engine: RTL and testbench
==================================

Name: ac_match_engine

Overview:
Aho-Corasick search walker that consumes the goto and failure tables.
- Accepts a stream of CHAR_W-bit input symbols with a valid/ready handshake.
- Per symbol: reads the goto table, follows failure links until a transition exists, then reads the per-state output mask.
- Emits a one-cycle match report carrying the resulting state, the symbol position and the pattern mask.
- Sits between the text source and the match collector; drives the lookup ports of the goto, failure and output tables.

Parameters:
STATE_W, 8, state index width
CHAR_W, 4, symbol width; goto address = {state, char} = STATE_W+CHAR_W bits
OUT_W, 8, pattern-match mask width
POS_W, 16, symbol position counter width
MAX_HOPS, 15, maximum failure hops per symbol before abort

Ports:
CLK  in  1  clock
RST  in  1  asynchronous, active-low reset
EN  in  1  engine enable; gates acceptance of new symbols only
CLR  in  1  sync clear of current state and position; honoured only in IDLE
CHAR_VALID  in  1  input symbol valid
CHAR_READY  out  1  engine can accept a symbol
CHAR  in  CHAR_W  input symbol
GOTO_RE  out  1  goto table read enable
GOTO_ADDR  out  STATE_W+CHAR_W  {state, char}
GOTO_RDATA  in  STATE_W  next state; all-ones means no transition
FAIL_RE  out  1  failure table read enable
FAIL_ADDR  out  STATE_W  state
FAIL_RDATA  in  STATE_W  failure state
OUT_RE  out  1  output table read enable
OUT_ADDR  out  STATE_W  state
OUT_RDATA  in  OUT_W  pattern mask for state (failure-inherited)
MATCH_VALID  out  1  one-cycle match pulse
MATCH_STATE  out  STATE_W  state reached
MATCH_POS  out  POS_W  index of the completing symbol
MATCH_MASK  out  OUT_W  nonzero pattern mask
ERR  out  1  sticky: hop limit exceeded
MATCH_CNT  out  16  match counter (optional feature)

Behaviour:
- Reset (RST low, asynchronous): FSM to IDLE; current state = ROOT (0); position = 0; hop count = 0.
- All outputs 0 during reset, including ERR, MATCH_* and the *_RE strobes.
- All tables are synchronous-read: data is valid the cycle after the RE strobe. The RE strobes and addresses are combinational from the FSM state.
- IDLE:
  - CHAR_READY = EN.
  - If CLR: current state = 0, position = 0, no symbol accepted that cycle. CLR takes priority over CHAR_VALID.
  - Otherwise, on CHAR_VALID && EN: latch the symbol, assert GOTO_RE with GOTO_ADDR = {cur, char}, go to GOTO.
- GOTO (GOTO_RDATA valid):
  - If != all-ones: cur <= GOTO_RDATA, assert OUT_RE at that state, go to OUT.
  - Else if cur == 0: root self-loop, cur stays 0, assert OUT_RE at 0, go to OUT.
  - Else if hops == MAX_HOPS: set ERR, cur <= 0, go to OUT at 0.
  - Else: assert FAIL_RE at cur, hops++, go to FAIL.
- FAIL: cur <= FAIL_RDATA; assert GOTO_RE at {FAIL_RDATA, char}; go to GOTO.
- OUT (OUT_RDATA valid):
  - If OUT_RDATA != 0: register MATCH_VALID = 1, MATCH_STATE = cur, MATCH_POS = pos, MATCH_MASK = OUT_RDATA, valid in the next cycle.
  - Always: pos++ (wraps modulo 2^POS_W), hops = 0, go to IDLE.
- MATCH_VALID is high exactly one cycle and has no backpressure. MATCH_STATE/POS/MASK hold their values until the next match.
- Timing without failure hops: symbol accepted at edge t; MATCH_VALID high in cycle t+3; CHAR_READY high again in cycle t+3. Each failure hop adds 2 cycles.
- EN deassertion mid-lookup: the in-flight symbol completes normally; no new symbol is accepted.
- RST mid-lookup: the in-flight symbol is discarded; no match is reported.
- ERR clears only on RST.

Optional Feature:
AC_MATCH_COUNT_EN
- Defined: MATCH_CNT counts MATCH_VALID pulses, saturates at 16'hFFFF, and clears on RST or CLR.
- Undefined: MATCH_CNT is tied to 0 and no counter logic is built.

Decomposition:
- Package ac_pkg: STATE_W, CHAR_W, OUT_W, ROOT_STATE = 0, NO_TRANS = all-ones, and the FSM state enum {IDLE, GOTO, FAIL, OUT}.
- One sub-module, ac_pos_counter: the position counter with wrap, plus the optional saturating match counter.

Test Plan:
All scenarios use one table set:
- goto: 0-1->1, 1-2->2, 0-3->3, 3-1->4, 4-2->5; every other entry is all-ones.
- fail: 4->1, 5->2; all other states fail to 0.
- output mask: 2 = 0x01, 5 = 0x03; all other states 0.

1. Reset, then symbols 3,1,2 -> single MATCH_VALID, STATE = 5, POS = 2, MASK = 0x03, 3 cycles after acceptance of the last symbol.
2. Symbols 1,1,2 -> second symbol takes one failure hop (1 -> 0 -> 1); match at STATE = 2, POS = 2, MASK = 0x01; the hop adds 2 cycles.
3. Goto forced all-ones everywhere plus a fail loop 1 <-> 4 with cur = 1 -> after 15 hops ERR = 1 and cur = 0; the next symbol is processed normally.
4. CLR and CHAR_VALID asserted together in IDLE -> symbol not accepted; state = 0, pos = 0; CHAR_READY stays high.
5. EN dropped the cycle after acceptance -> the in-flight match is still reported; CHAR_READY stays 0 until EN returns.
6. With AC_MATCH_COUNT_EN defined, feed 3,1,2 twice -> MATCH_CNT = 2, POS values 2 and 5. With the macro undefined, MATCH_CNT = 0.

Source files
------------

// File: rtl/ac_pkg.sv
// Shared widths, table sentinels and FSM encoding for the Aho-Corasick match engine.
package ac_pkg;
    localparam int STATE_W  = 8;
    localparam int CHAR_W   = 4;
    localparam int OUT_W    = 8;
    localparam int POS_W    = 16;
    localparam int MAX_HOPS = 15;

    localparam logic [STATE_W-1:0] ROOT_STATE = '0;
    localparam logic [STATE_W-1:0] NO_TRANS   = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GOTO = 2'd1,
        FAIL = 2'd2,
        OUT  = 2'd3
    } ac_state_e;
endpackage

// File: rtl/ac_pos_counter.sv
// Symbol position counter (wraps) plus optional saturating match counter.
// Optional counter is built only when AC_MATCH_COUNT_EN is defined.
module ac_pos_counter
    import ac_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    input  logic             i_match,
    output logic [POS_W-1:0] o_pos,
    output logic [15:0]      o_match_cnt
);
    logic [POS_W-1:0] r_pos;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pos <= '0;
        end else if (i_clr) begin
            r_pos <= '0;
        end else if (i_inc) begin
            r_pos <= r_pos + 1'b1;
        end
    end

    assign o_pos = r_pos;

`ifdef AC_MATCH_COUNT_EN
    logic [15:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_match && (r_cnt != 16'hFFFF)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_match_cnt = r_cnt;
`else
    logic w_unused_match;
    assign w_unused_match = i_match;
    assign o_match_cnt    = '0;
`endif
endmodule

// File: rtl/ac_match_engine.sv
// Aho-Corasick walker: goto lookup, failure-link hops, output-mask lookup, one-cycle match report.
// Define AC_MATCH_COUNT_EN to build the saturating match counter behind o_match_cnt.
module ac_match_engine
    import ac_pkg::*;
(
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_en,
    input  logic                      i_clr,
    input  logic                      i_char_valid,
    output logic                      o_char_ready,
    input  logic [CHAR_W-1:0]         i_char,
    output logic                      o_goto_re,
    output logic [STATE_W+CHAR_W-1:0] o_goto_addr,
    input  logic [STATE_W-1:0]        i_goto_rdata,
    output logic                      o_fail_re,
    output logic [STATE_W-1:0]        o_fail_addr,
    input  logic [STATE_W-1:0]        i_fail_rdata,
    output logic                      o_out_re,
    output logic [STATE_W-1:0]        o_out_addr,
    input  logic [OUT_W-1:0]          i_out_rdata,
    output logic                      o_match_valid,
    output logic [STATE_W-1:0]        o_match_state,
    output logic [POS_W-1:0]          o_match_pos,
    output logic [OUT_W-1:0]          o_match_mask,
    output logic                      o_err,
    output logic [15:0]               o_match_cnt,
    output logic [1:0]                o_dbg_state
);
    localparam int HOP_W = $clog2(MAX_HOPS + 1);

    ac_state_e          r_state, w_next;
    logic [STATE_W-1:0] r_cur;
    logic [CHAR_W-1:0]  r_char;
    logic [HOP_W-1:0]   r_hops;
    logic               r_err;
    logic               r_match_valid;
    logic [STATE_W-1:0] r_match_state;
    logic [POS_W-1:0]   r_match_pos;
    logic [OUT_W-1:0]   r_match_mask;
    logic [POS_W-1:0]   w_pos;
    logic               w_clr, w_accept, w_goto_hit, w_at_root, w_hop_lim;

    // Handshake: a symbol transfers on a rising edge where i_char_valid and o_char_ready are both high.
    assign w_clr      = (r_state == IDLE) && i_clr;
    assign w_accept   = (r_state == IDLE) && !i_clr && i_char_valid && i_en;
    assign w_goto_hit = (i_goto_rdata != NO_TRANS);
    assign w_at_root  = (r_cur == ROOT_STATE);
    assign w_hop_lim  = (r_hops == HOP_W'(MAX_HOPS));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = GOTO;
            GOTO:    w_next = (w_goto_hit || w_at_root || w_hop_lim) ? OUT : FAIL;
            FAIL:    w_next = GOTO;
            OUT:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Table strobes are combinational from the FSM and forced low while in reset.
    always_comb begin
        o_char_ready = 1'b0;
        o_goto_re    = 1'b0;
        o_goto_addr  = '0;
        o_fail_re    = 1'b0;
        o_fail_addr  = '0;
        o_out_re     = 1'b0;
        o_out_addr   = '0;
        if (i_rst_n) begin
            case (r_state)
                IDLE: begin
                    o_char_ready = i_en;
                    if (w_accept) begin
                        o_goto_re   = 1'b1;
                        o_goto_addr = {r_cur, i_char};
                    end
                end
                GOTO: begin
                    if (w_goto_hit) begin
                        o_out_re   = 1'b1;
                        o_out_addr = i_goto_rdata;
                    end else if (w_at_root || w_hop_lim) begin
                        o_out_re   = 1'b1;
                        o_out_addr = ROOT_STATE;
                    end else begin
                        o_fail_re   = 1'b1;
                        o_fail_addr = r_cur;
                    end
                end
                FAIL: begin
                    o_goto_re   = 1'b1;
                    o_goto_addr = {i_fail_rdata, r_char};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cur         <= ROOT_STATE;
            r_char        <= '0;
            r_hops        <= '0;
            r_err         <= 1'b0;
            r_match_valid <= 1'b0;
            r_match_state <= '0;
            r_match_pos   <= '0;
            r_match_mask  <= '0;
        end else begin
            r_match_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_clr)         r_cur  <= ROOT_STATE;
                    else if (w_accept) r_char <= i_char;
                end
                GOTO: begin
                    if (w_goto_hit) begin
                        r_cur <= i_goto_rdata;
                    end else if (!w_at_root) begin
                        if (w_hop_lim) begin
                            r_err <= 1'b1;
                            r_cur <= ROOT_STATE;
                        end else begin
                            r_hops <= r_hops + 1'b1;
                        end
                    end
                end
                FAIL: r_cur <= i_fail_rdata;
                OUT: begin
                    r_hops <= '0;
                    if (i_out_rdata != '0) begin
                        r_match_valid <= 1'b1;
                        r_match_state <= r_cur;
                        r_match_pos   <= w_pos;
                        r_match_mask  <= i_out_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    ac_pos_counter u_pos (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_clr       (w_clr),
        .i_inc       (r_state == OUT),
        .i_match     (r_match_valid),
        .o_pos       (w_pos),
        .o_match_cnt (o_match_cnt)
    );

    assign o_match_valid = r_match_valid;
    assign o_match_state = r_match_state;
    assign o_match_pos   = r_match_pos;
    assign o_match_mask  = r_match_mask;
    assign o_err         = r_err;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_ac_match_engine.sv
// Directed scoreboard bench for ac_match_engine with a behavioural goto/failure/output table set.
module tb_ac_match_engine;
    import ac_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst_n, i_en, i_clr, i_char_valid;
    logic [3:0]  i_char;
    logic        o_char_ready, o_goto_re, o_fail_re, o_out_re;
    logic [11:0] o_goto_addr;
    logic [7:0]  o_fail_addr, o_out_addr;
    logic [7:0]  goto_rdata = '0, fail_rdata = '0, out_rdata = '0;
    logic        o_match_valid, o_err;
    logic [7:0]  o_match_state, o_match_mask;
    logic [15:0] o_match_pos, o_match_cnt;
    logic [1:0]  o_dbg_state;

    logic [31:0] exp_q[$];
    int          exp_cyc_q[$];
    int          n_checks = 0, n_fail = 0, cyc = 0, exp_matches = 0;
    bit          forced = 1'b0;

    always #5 i_clk = ~i_clk;

    ac_match_engine dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_clr(i_clr),
        .i_char_valid(i_char_valid), .o_char_ready(o_char_ready), .i_char(i_char),
        .o_goto_re(o_goto_re), .o_goto_addr(o_goto_addr), .i_goto_rdata(goto_rdata),
        .o_fail_re(o_fail_re), .o_fail_addr(o_fail_addr), .i_fail_rdata(fail_rdata),
        .o_out_re(o_out_re), .o_out_addr(o_out_addr), .i_out_rdata(out_rdata),
        .o_match_valid(o_match_valid), .o_match_state(o_match_state),
        .o_match_pos(o_match_pos), .o_match_mask(o_match_mask),
        .o_err(o_err), .o_match_cnt(o_match_cnt), .o_dbg_state(o_dbg_state)
    );

    function automatic logic [7:0] goto_f(input logic [11:0] a);
        if (forced) return 8'hFF;
        case (a)
            12'h001: return 8'd1;
            12'h012: return 8'd2;
            12'h003: return 8'd3;
            12'h031: return 8'd4;
            12'h042: return 8'd5;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [7:0] fail_f(input logic [7:0] s);
        if (forced) return (s == 8'd1) ? 8'd4 : (s == 8'd4) ? 8'd1 : 8'd0;
        return (s == 8'd4) ? 8'd1 : (s == 8'd5) ? 8'd2 : 8'd0;
    endfunction

    function automatic logic [7:0] out_f(input logic [7:0] s);
        return (s == 8'd2) ? 8'h01 : (s == 8'd5) ? 8'h03 : 8'h00;
    endfunction

    // Synchronous-read table models
    always @(posedge i_clk) begin
        if (o_goto_re) goto_rdata <= goto_f(o_goto_addr);
        if (o_fail_re) fail_rdata <= fail_f(o_fail_addr);
        if (o_out_re)  out_rdata  <= out_f(o_out_addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: cycle count at each falling edge; pops the scoreboard on every match pulse
    always @(negedge i_clk) begin
        logic [31:0] m;
        int          c;
        cyc = cyc + 1;
        if (o_match_valid) begin
            if (exp_q.size() == 0) begin
                check("match_expected", 32'(exp_q.size()), 32'd1);
            end else begin
                m = exp_q.pop_front();
                c = exp_cyc_q.pop_front();
                check("match_fields", {o_match_state, o_match_pos, o_match_mask}, m);
                check("match_cycle", 32'(cyc), 32'(c));
            end
        end
    end

    task automatic push_match(input int acc, input int hops, input logic [31:0] m);
        exp_q.push_back(m);
        exp_cyc_q.push_back(acc + 3 + 2 * hops);
        exp_matches++;
    endtask

    task automatic wait_ready(input string name, input int exp_k);
        int k;
        k = 0;
        do begin
            @(negedge i_clk);
            k++;
        end while (!o_char_ready && k < 200);
        check(name, 32'(k), 32'(exp_k));
    endtask

    task automatic send(input logic [3:0] c, input int hops, input bit has_m, input logic [31:0] m);
        @(negedge i_clk);
        i_char       = c;
        i_char_valid = 1'b1;
        check("ready_before_send", 32'(o_char_ready), 32'd1);
        @(posedge i_clk);
        if (has_m) push_match(cyc, hops, m);
        #1 i_char_valid = 1'b0;
        wait_ready("ready_latency", 3 + 2 * hops);
    endtask

    task automatic do_clr();
        @(negedge i_clk);
        i_clr = 1'b1;
        @(negedge i_clk);
        i_clr = 1'b0;
        exp_matches = 0;
    endtask

    initial begin
        int acc;
        i_rst_n = 1'b0; i_en = 1'b1; i_clr = 1'b0; i_char_valid = 1'b1; i_char = 4'd1;
        repeat (3) @(negedge i_clk);
        check("rst_char_ready", 32'(o_char_ready), 32'd0);
        check("rst_goto_re", 32'(o_goto_re), 32'd0);
        check("rst_match", {o_match_valid, o_match_state, o_match_pos[6:0], o_match_mask}, 32'd0);
        check("rst_err_cnt", {o_err, o_match_cnt}, 32'd0);
        check("rst_state", 32'(o_dbg_state), 32'(IDLE));
        i_char_valid = 1'b0;
        i_rst_n      = 1'b1;
        @(negedge i_clk);
        check("idle_ready", 32'(o_char_ready), 32'd1);

        // Plain walk 0 -3-> 3 -1-> 4 -2-> 5
        send(4'd3, 0, 1'b0, '0);
        send(4'd1, 0, 1'b0, '0);
        send(4'd2, 0, 1'b1, {8'd5, 16'd2, 8'h03});

        // One failure hop on the second symbol
        do_clr();
        send(4'd1, 0, 1'b0, '0);
        send(4'd1, 1, 1'b0, '0);
        send(4'd2, 0, 1'b1, {8'd2, 16'd2, 8'h01});

        // Hop limit: 1 <-> 4 failure loop with no transitions anywhere
        do_clr();
        send(4'd1, 0, 1'b0, '0);
        forced = 1'b1;
        send(4'd5, MAX_HOPS, 1'b0, '0);
        check("err_set", 32'(o_err), 32'd1);
        forced = 1'b0;
        send(4'd1, 0, 1'b0, '0);
        send(4'd2, 0, 1'b1, {8'd2, 16'd3, 8'h01});
        check("err_sticky", 32'(o_err), 32'd1);

        // Clear beats a simultaneous valid symbol
        @(negedge i_clk);
        i_clr = 1'b1; i_char_valid = 1'b1; i_char = 4'd1;
        #1;
        check("clr_ready", 32'(o_char_ready), 32'd1);
        check("clr_no_goto", 32'(o_goto_re), 32'd0);
        @(negedge i_clk);
        check("clr_state", 32'(o_dbg_state), 32'(IDLE));
        i_clr = 1'b0; i_char_valid = 1'b0; exp_matches = 0;
        send(4'd1, 0, 1'b0, '0);
        send(4'd2, 0, 1'b1, {8'd2, 16'd1, 8'h01});

        // Enable dropped mid-lookup
        do_clr();
        send(4'd1, 0, 1'b0, '0);
        @(negedge i_clk);
        i_char = 4'd2; i_char_valid = 1'b1;
        @(posedge i_clk);
        push_match(cyc, 0, {8'd2, 16'd1, 8'h01});
        @(negedge i_clk);
        i_en = 1'b0; i_char = 4'd3;
        for (int i = 0; i < 6; i++) begin
            @(negedge i_clk);
            check("ready_en_low", 32'(o_char_ready), 32'd0);
        end
        i_en = 1'b1;
        #1 check("ready_en_back", 32'(o_char_ready), 32'd1);
        @(posedge i_clk);
        #1 i_char_valid = 1'b0;
        wait_ready("ready_latency", 5);

        // Two matches in one stream; second '3' takes two hops (5 -> 2 -> 0)
        do_clr();
        send(4'd3, 0, 1'b0, '0);
        send(4'd1, 0, 1'b0, '0);
        send(4'd2, 0, 1'b1, {8'd5, 16'd2, 8'h03});
        send(4'd3, 2, 1'b0, '0);
        send(4'd1, 0, 1'b0, '0);
        send(4'd2, 0, 1'b1, {8'd5, 16'd5, 8'h03});
        repeat (2) @(negedge i_clk);
`ifdef AC_MATCH_COUNT_EN
        check("match_cnt", 32'(o_match_cnt), 32'(exp_matches));
`else
        check("match_cnt", 32'(o_match_cnt), 32'd0);
`endif

        // Reset mid-lookup discards the in-flight symbol
        do_clr();
        send(4'd1, 0, 1'b0, '0);
        @(negedge i_clk);
        i_char = 4'd2; i_char_valid = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b0; exp_matches = 0;
        #1;
        check("midrst_outputs", {o_match_valid, o_err, o_goto_re, o_fail_re, o_out_re, o_char_ready}, 32'd0);
        check("midrst_cnt", 32'(o_match_cnt), 32'd0);
        i_char_valid = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (6) @(negedge i_clk);
        check("midrst_idle", {o_char_ready, o_dbg_state}, {1'b1, 2'(IDLE)});

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge i_clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
